// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the load/store path: access widths, funct3 codes,
// LSU fault codes, LSU states and the load-extension helper.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] CODE_START = 32'h8000_0000;
  localparam logic [XLEN-1:0] DATA_START = 32'hC000_0000;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } Width;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    ACCESS     = 2'd2,
    ILLEGAL    = 2'd3
  } LsuFault;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_ARM,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] data,
                                                  input Width w,
                                                  input logic sign_ext);
    logic [XLEN-1:0] r;
    case (w)
      BYTE:     r = {{24{sign_ext & data[7]}}, data[7:0]};
      HALFWORD: r = {{16{sign_ext & data[15]}}, data[15:0]};
      default:  r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of a load/store request: width, sign, fault, aligned address, store data.
// Misaligned halfword/word accesses trap when LSU_MISALIGN_TRAP_EN is defined, else align down.
module lsu_decode
  import riscv_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DATA_START,
  parameter int unsigned DATA_BYTES = 65536
) (
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output Width        width,
  output logic        sign_ext,
  output LsuFault     fault,
  output logic [31:0] addr_aligned,
  output logic [31:0] wdata_masked
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_window;
  logic [1:0]  span;
  logic [32:0] last_byte;
  logic [32:0] window_end;

  always_comb begin
    illegal = 1'b0;
    width   = BYTE;
    span    = 2'd0;
    case (funct3)
      F3_B, F3_BU: begin width = BYTE;     span = 2'd0; end
      F3_H, F3_HU: begin width = HALFWORD; span = 2'd1; end
      F3_W:        begin width = WORD;     span = 2'd3; end
      default:     illegal = 1'b1;
    endcase
    if (store && funct3[2]) illegal = 1'b1;
    sign_ext = ~funct3[2];

    addr_aligned = addr;
    misaligned   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = |(addr[1:0] & span);
`else
    addr_aligned[1:0] = addr[1:0] & ~span;
`endif

    // 33-bit compare so an access running past 0xFFFF_FFFF cannot wrap into range
    last_byte     = {1'b0, addr_aligned} + {31'b0, span};
    window_end    = {1'b0, DATA_BASE} + 33'(DATA_BYTES);
    out_of_window = (addr_aligned < DATA_BASE) || (last_byte >= window_end);

    if (illegal)            fault = ILLEGAL;
    else if (misaligned)    fault = MISALIGNED;
    else if (out_of_window) fault = ACCESS;
    else                    fault = NONE;

    case (width)
      BYTE:     wdata_masked = {24'b0, wdata[7:0]};
      HALFWORD: wdata_masked = {16'b0, wdata[15:0]};
      default:  wdata_masked = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and the memory data port; one request in flight at a time.
// Misaligned behaviour is selected in lsu_decode by LSU_MISALIGN_TRAP_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// LSU_IDLE  | req_ready=1; accept, decode, go to ISSUE or straight to RESP on fault
// LSU_ISSUE | one-cycle read/write request pulse to memory
// LSU_ARM   | busy_main ignored while the memory raises it
// LSU_WAIT  | wait for busy_main low, capture load data
// LSU_RESP  | resp_valid pulse, then back to IDLE
module load_store_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DATA_START,
  parameter int unsigned DATA_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] address_main,
  output logic [3:0]  width,
  output logic        read_request_main,
  output logic        write_request_main,
  output logic [31:0] write_data_main,
  input  logic [31:0] data_main,
  input  logic        busy_main
);

  lsu_state_e  state, state_next;
  Width        dec_width, op_width;
  logic        dec_sign, op_sign, op_store;
  LsuFault     dec_fault;
  logic [31:0] dec_addr, dec_wdata;
  logic        xfer;
  logic        load_done;

  lsu_decode #(
    .DATA_BASE (DATA_BASE),
    .DATA_BYTES(DATA_BYTES)
  ) u_decode (
    .funct3      (req_funct3),
    .store       (req_store),
    .addr        (req_addr),
    .wdata       (req_wdata),
    .width       (dec_width),
    .sign_ext    (dec_sign),
    .fault       (dec_fault),
    .addr_aligned(dec_addr),
    .wdata_masked(dec_wdata)
  );

  // Gated by rst so execute never sees ready while reset is held
  assign req_ready = (state == LSU_IDLE) && !rst;
  assign xfer      = req_valid && req_ready;
  assign load_done = (state == LSU_WAIT) && !busy_main && !op_store;
  assign width     = {2'b00, op_width};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next         = state;
    read_request_main  = 1'b0;
    write_request_main = 1'b0;
    resp_valid         = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (xfer) state_next = (dec_fault != NONE) ? LSU_RESP : LSU_ISSUE;
      end
      LSU_ISSUE: begin
        read_request_main  = !op_store;
        write_request_main = op_store;
        state_next         = LSU_ARM;
      end
      LSU_ARM:  state_next = LSU_WAIT;
      LSU_WAIT: begin
        if (!busy_main) state_next = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        state_next = LSU_IDLE;
      end
      default:  state_next = LSU_IDLE;
    endcase
  end

  // Memory-side fields only move on an accepted, fault-free request so they stay
  // stable from ISSUE through WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_store        <= 1'b0;
      op_sign         <= 1'b0;
      op_width        <= BYTE;
      address_main    <= '0;
      write_data_main <= '0;
      resp_rdata      <= '0;
      resp_fault      <= NONE;
    end else begin
      if (xfer) begin
        resp_fault <= dec_fault;
        resp_rdata <= '0;
        if (dec_fault == NONE) begin
          op_store        <= req_store;
          op_sign         <= dec_sign;
          op_width        <= dec_width;
          address_main    <= dec_addr;
          write_data_main <= dec_wdata;
        end
      end
      if (load_done) resp_rdata <= extend_load(data_main, op_width, op_sign);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed, fault, randomized, back-to-back and reset cases
// against an arithmetic reference model and a simple busy-profile memory.
module tb_load_store_unit;

  localparam logic [31:0] BASE    = 32'hC000_0000;
  localparam longint      BASE_L  = 64'hC000_0000;
  localparam longint      BYTES_L = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] address_main;
  logic [3:0]  width;
  logic        read_request_main, write_request_main;
  logic [31:0] write_data_main, data_main;
  logic        busy_main;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_BASE(BASE), .DATA_BYTES(65536)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .address_main(address_main), .width(width),
    .read_request_main(read_request_main), .write_request_main(write_request_main),
    .write_data_main(write_data_main), .data_main(data_main), .busy_main(busy_main)
  );

  // Reference: what a load/store should do, from the architectural rules
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] md,
                                output int fault, output logic [31:0] ea,
                                output logic [31:0] ewd, output logic [31:0] erd,
                                output logic [3:0] ew);
    longint nb, addr_l, val, mask, one;
    int     f;
    bit     illegal;
    f       = int'(f3);
    illegal = (f == 3) || (f >= 6) || (st && f >= 4);
    one     = 1;
    nb      = one << (f % 4);
    mask    = (one << (8 * nb)) - 1;
    addr_l  = longint'(a);
    fault   = 0;
    if (illegal) fault = 3;
    else begin
`ifdef LSU_MISALIGN_TRAP_EN
      if (addr_l % nb != 0) fault = 1;
`else
      addr_l = addr_l - (addr_l % nb);
`endif
      if (fault == 0 && !(addr_l >= BASE_L && addr_l + nb <= BASE_L + BYTES_L)) fault = 2;
    end
    ea  = addr_l[31:0];
    ew  = 4'(f % 4);
    val = longint'(wd) & mask;
    ewd = val[31:0];
    val = longint'(md) & mask;
    if (f < 4 && val > (mask >> 1)) val = val - (mask + 1);
    erd = (st || fault != 0) ? 32'h0 : val[31:0];
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the response
  task automatic run_txn(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                         input int bc);
    int ef, bce, exp_cyc, got_cyc, nrd, nwr;
    logic [31:0] ea, ewd, erd;
    logic [3:0]  ew;
    model(st, f3, a, wd, md, ef, ea, ewd, erd, ew);
    bce     = (st && ew == 4'd0) ? 0 : bc;   // byte writes never raise busy
    exp_cyc = (ef != 0) ? 1 : ((3 + bce > 4) ? 3 + bce : 4);

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_start: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    data_main = md; busy_main = 1'b0;
    nrd = 0; nwr = 0; got_cyc = -1;

    for (int c = 1; c < 64 && got_cyc < 0; c++) begin
      @(negedge clk);
      req_valid  = 1'($urandom);    // not IDLE here, must be ignored
      req_store  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      busy_main  = (c >= 2 && c < 2 + bce);
      nrd += int'(read_request_main);
      nwr += int'(write_request_main);
      if (c == 1) begin
        checks++;
        if (read_request_main !== (ef == 0 && !st) || write_request_main !== (ef == 0 && st)) begin
          errors++;
          $display("FAIL %s issue_pulse: got rd=%b wr=%b want rd=%b wr=%b", name,
                   read_request_main, write_request_main, (ef == 0 && !st), (ef == 0 && st));
        end
      end
      if (ef == 0 && c < exp_cyc) begin
        checks++;
        if ({address_main, width, write_data_main} !== {ea, ew, ewd}) begin
          errors++;
          $display("FAIL %s mem_fields c=%0d: got addr=%h w=%0d wd=%h want addr=%h w=%0d wd=%h",
                   name, c, address_main, width, write_data_main, ea, ew, ewd);
        end
      end
      if (resp_valid === 1'b1) begin
        got_cyc = c;
        checks++;
        if (c != exp_cyc || resp_rdata !== erd || resp_fault !== 2'(ef)) begin
          errors++;
          $display("FAIL %s response: got cyc=%0d rdata=%h fault=%0d want cyc=%0d rdata=%h fault=%0d",
                   name, c, resp_rdata, resp_fault, exp_cyc, erd, ef);
        end
      end
    end
    if (got_cyc < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no resp_valid want one at cycle %0d", name, exp_cyc);
    end
    checks++;
    if (nrd != ((ef == 0 && !st) ? 1 : 0) || nwr != ((ef == 0 && st) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s request_count: got rd=%0d wr=%0d want rd=%0d wr=%0d", name, nrd, nwr,
               (ef == 0 && !st) ? 1 : 0, (ef == 0 && st) ? 1 : 0);
    end
    @(negedge clk);
    req_valid = 1'b0; busy_main = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_resp: got ready=%b valid=%b want ready=1 valid=0", name, req_ready, resp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_fault, read_request_main, write_request_main,
         address_main, width, write_data_main} !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs: got ready=%b v=%b rd=%h f=%0d rr=%b wr=%b a=%h w=%0d wd=%h want all 0",
               name, req_ready, resp_valid, resp_rdata, resp_fault, read_request_main,
               write_request_main, address_main, width, write_data_main);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; data_main = '0; busy_main = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    run_txn("lb_sign",   1'b0, 3'b000, 32'hC000_0010, $urandom, 32'h0000_0080, 2);
    run_txn("lhu_busy4", 1'b0, 3'b101, 32'hC000_0002, $urandom, 32'h0000_8001, 4);
    run_txn("sw_word",   1'b1, 3'b010, 32'hC000_0100, 32'hDEAD_BEEF, $urandom, 3);
    run_txn("lw_misal",  1'b0, 3'b010, 32'hC000_0002, $urandom, 32'h1234_5678, 1);
    run_txn("sb_nobusy", 1'b1, 3'b000, 32'hC000_0033, 32'hA5A5_A5C3, $urandom, 0);
    run_txn("sh_mask",   1'b1, 3'b001, 32'hC000_0044, 32'h1357_9BDF, $urandom, 2);
    run_txn("lh_sign",   1'b0, 3'b001, 32'hC000_0046, $urandom, 32'h7777_F00D, 0);
  endtask

  task automatic test_faults();
    run_txn("lw_code",   1'b0, 3'b010, 32'h8000_0000, $urandom, $urandom, 2);
    run_txn("sw_top",    1'b1, 3'b010, 32'hC000_FFFE, $urandom, $urandom, 2);
    run_txn("f3_011",    1'b0, 3'b011, 32'hC000_0000, $urandom, $urandom, 2);
    run_txn("f3_111",    1'b0, 3'b111, 32'h8000_0003, $urandom, $urandom, 2);
    run_txn("sbu_store", 1'b1, 3'b100, 32'hC000_0000, $urandom, $urandom, 2);
    run_txn("lb_past",   1'b0, 3'b000, 32'hC001_0000, $urandom, $urandom, 2);
    run_txn("lb_below",  1'b0, 3'b100, 32'hBFFF_FFFF, $urandom, $urandom, 2);
    run_txn("lb_last",   1'b0, 3'b100, 32'hC000_FFFF, $urandom, 32'h0000_00FE, 1);
    run_txn("lh_last",   1'b0, 3'b001, 32'hC000_FFFF, $urandom, 32'h0000_8000, 1);
    run_txn("lw_wrap",   1'b0, 3'b010, 32'hFFFF_FFFC, $urandom, $urandom, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: a = BASE + ($urandom % 65536);
        2:    a = BASE + 32'd65536 - ($urandom % 8);
        default: a = BASE - ($urandom % 8);
      endcase
      run_txn("random", 1'($urandom), 3'($urandom), a, $urandom, $urandom, $urandom_range(0, 6));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_txn("b2b", 1'(i % 2), 3'(i % 3), BASE + 32'(i * 4), $urandom, $urandom, 0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = BASE + 32'h40;
    req_wdata = $urandom; data_main = $urandom; busy_main = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); busy_main = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk); busy_main = 1'b0; rst = 1'b0;
    @(negedge clk);
    run_txn("lb_after_rst", 1'b0, 3'b000, 32'hC000_0021, $urandom, 32'h0000_007F, 2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
